// File: rtl/core_pkg.sv
// Shared RV32IM core definitions: datapath width, load funct3 encodings and
// the writeback request record.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // Which source owns the register file write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_BUF  = 2'd2,
        SRC_MD   = 2'd3
    } wb_src_e;

endpackage

// File: rtl/wb_stage_if.sv
// Writeback stage bus: MEM pipeline result, mul/div handshake, issue
// notification, busy scoreboard and register file write port.
interface wb_stage_if;
    import core_pkg::*;

    logic            pipe_valid;
    logic [4:0]      pipe_rd;
    logic            pipe_is_load;
    logic [2:0]      pipe_funct3;
    logic [1:0]      pipe_addr_lo;
    logic [XLEN-1:0] pipe_alu_result;
    logic [XLEN-1:0] pipe_mem_rdata;
    logic            pipe_stall;

    logic            md_valid;
    logic            md_ready;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_result;

    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [31:0]     busy;

    logic [4:0]      write_register;
    logic [XLEN-1:0] write_data;
    logic            reg_write;

    modport master (
        output pipe_valid, pipe_rd, pipe_is_load, pipe_funct3, pipe_addr_lo,
               pipe_alu_result, pipe_mem_rdata,
               md_valid, md_rd, md_result, iss_valid, iss_rd,
        input  pipe_stall, md_ready, busy, write_register, write_data, reg_write
    );

    modport slave (
        input  pipe_valid, pipe_rd, pipe_is_load, pipe_funct3, pipe_addr_lo,
               pipe_alu_result, pipe_mem_rdata,
               md_valid, md_rd, md_result, iss_valid, iss_rd,
        output pipe_stall, md_ready, busy, write_register, write_data, reg_write
    );

endinterface

// File: rtl/load_ext.sv
// Load data extraction: picks the addressed byte/half from an aligned word
// and sign- or zero-extends it. Purely combinational, shared with forwarding.
module load_ext
    import core_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        case (i_funct3)
            LB:      o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            LBU:     o_data = {{(XLEN-8){1'b0}}, w_byte};
            LH:      o_data = {{(XLEN-16){w_half[15]}}, w_half};
            LHU:     o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates the in-order pipeline result against a one-entry
// mul/div skid buffer and tracks registers owned by in-flight mul/div ops.
module wb_stage
    import core_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    wb_stage_if.slave  bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic            r_buf_valid;
    wb_req_t         r_buf;
    logic [CW-1:0]   r_starve;
    logic [31:0]     r_busy;
    logic [4:0]      r_write_register;
    logic [XLEN-1:0] r_write_data;
    logic            r_reg_write;

    logic [XLEN-1:0] w_load_data;
    wb_req_t         w_pipe_req;
    wb_req_t         w_md_req;
    wb_req_t         w_commit;
    wb_src_e         w_src;
    logic            w_md_hs;
    logic            w_stall;
    logic            w_buf_load;
    logic            w_md_commit;
    logic [31:0]     w_busy_next;

    load_ext u_load_ext (
        .i_funct3  (bus.pipe_funct3),
        .i_addr_lo (bus.pipe_addr_lo),
        .i_rdata   (bus.pipe_mem_rdata),
        .o_data    (w_load_data)
    );

    assign w_pipe_req.rd   = bus.pipe_rd;
    assign w_pipe_req.data = bus.pipe_is_load ? w_load_data : bus.pipe_alu_result;
    assign w_md_req.rd     = bus.md_rd;
    assign w_md_req.data   = bus.md_result;

    // The buffer accepts only when empty, so md_ready never looks at md_valid.
    assign w_md_hs = bus.md_valid && !r_buf_valid;
    assign w_stall = r_buf_valid && (r_starve == CW'(STARVE_LIMIT));

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        w_src      = SRC_NONE;
        w_buf_load = 1'b0;
        if (w_stall) begin
            w_src = SRC_BUF;
        end else if (bus.pipe_valid) begin
            w_src      = SRC_PIPE;
            w_buf_load = w_md_hs;
        end else if (r_buf_valid) begin
            w_src = SRC_BUF;
        end else if (w_md_hs) begin
            w_src = SRC_MD;
        end
    end

    always_comb begin
        case (w_src)
            SRC_PIPE: w_commit = w_pipe_req;
            SRC_BUF:  w_commit = r_buf;
            SRC_MD:   w_commit = w_md_req;
            default:  w_commit = '0;
        endcase
    end

    assign w_md_commit = (w_src == SRC_BUF) || (w_src == SRC_MD);

    // Issue is applied after the commit clear so a same-cycle re-issue wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_md_commit) begin
            w_busy_next[w_commit.rd] = 1'b0;
        end
        if (bus.iss_valid) begin
            w_busy_next[bus.iss_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_buf_valid      <= 1'b0;
            // NOTE: payload is cleared too so a discarded result cannot leak out later.
            r_buf            <= '0;
            r_starve         <= '0;
            r_busy           <= '0;
            r_write_register <= '0;
            r_write_data     <= '0;
            r_reg_write      <= 1'b0;
        end else begin
            r_busy <= w_busy_next;

            if (w_src != SRC_NONE) begin
                r_write_register <= w_commit.rd;
                r_write_data     <= w_commit.data;
                r_reg_write      <= (w_commit.rd != 5'd0);
            end else begin
                r_reg_write <= 1'b0;
            end

            if (w_buf_load) begin
                r_buf_valid <= 1'b1;
                r_buf       <= w_md_req;
            end else if (w_src == SRC_BUF) begin
                r_buf_valid <= 1'b0;
            end

            if (w_src == SRC_BUF) begin
                r_starve <= '0;
            end else if (r_buf_valid && (r_starve != CW'(STARVE_LIMIT))) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    assign bus.md_ready       = !r_buf_valid;
    assign bus.pipe_stall     = w_stall;
    assign bus.busy           = r_busy;
    assign bus.write_register = r_write_register;
    assign bus.write_data     = r_write_data;
    assign bus.reg_write      = r_reg_write;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed scenarios plus random traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_wb_stage;
    import core_pkg::*;

    localparam int LIMIT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    wb_stage_if bus ();

    wb_stage #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        exp_q[$];   // commits due on the register file port
    exp_t        pend_q[$];  // mul/div result waiting for the port (0 or 1)
    int          losses;
    logic [31:0] m_busy;

    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_alo [5] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                                32'h0000_7F01, 32'h80FF_7F01};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural load result computed with shifts and two's-complement arithmetic.
    function automatic logic [31:0] ref_value(input logic is_load, input logic [2:0] f3,
                                              input logic [1:0] alo, input logic [31:0] alu,
                                              input logic [31:0] mem);
        logic [31:0] b;
        logic [31:0] h;
        if (!is_load) return alu;
        b = (mem >> (8 * int'(alo))) & 32'h0000_00FF;
        h = (mem >> (16 * int'(alo[1]))) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b ^ 32'h80) - 32'h80;
            3'b100:  return b;
            3'b001:  return (h ^ 32'h8000) - 32'h8000;
            3'b101:  return h;
            default: return mem;
        endcase
    endfunction

    // Monitor: every visible write must match the oldest expected commit.
    always @(negedge clk) begin
        if (reset && bus.reg_write) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_commit: got rd=%0d data=%h, expected no write",
                         bus.write_register, bus.write_data);
            end else begin
                e = exp_q.pop_front();
                check("commit_rd", 32'(bus.write_register), 32'(e.rd));
                check("commit_data", bus.write_data, e.data);
            end
        end
    end

    task automatic idle();
        bus.pipe_valid      = 1'b0;
        bus.pipe_rd         = '0;
        bus.pipe_is_load    = 1'b0;
        bus.pipe_funct3     = '0;
        bus.pipe_addr_lo    = '0;
        bus.pipe_alu_result = '0;
        bus.pipe_mem_rdata  = '0;
        bus.md_valid        = 1'b0;
        bus.md_rd           = '0;
        bus.md_result       = '0;
        bus.iss_valid       = 1'b0;
        bus.iss_rd          = '0;
    endtask

    task automatic set_pipe(input logic [4:0] rd, input logic is_load, input logic [2:0] f3,
                            input logic [1:0] alo, input logic [31:0] alu, input logic [31:0] mem);
        bus.pipe_valid      = 1'b1;
        bus.pipe_rd         = rd;
        bus.pipe_is_load    = is_load;
        bus.pipe_funct3     = f3;
        bus.pipe_addr_lo    = alo;
        bus.pipe_alu_result = alu;
        bus.pipe_mem_rdata  = mem;
    endtask

    task automatic set_md(input logic [4:0] rd, input logic [31:0] res);
        bus.md_valid  = 1'b1;
        bus.md_rd     = rd;
        bus.md_result = res;
    endtask

    // One clock: predict who owns the write port, advance the model, check state.
    task automatic cycle(output bit pipe_taken, output bit md_taken);
        bit   stall;
        bit   have;
        bit   md_commit;
        exp_t c;
        exp_t ld;
        #1;
        stall = (pend_q.size() != 0) && (losses == LIMIT);
        check("md_ready", 32'(bus.md_ready), 32'(pend_q.size() == 0));
        check("pipe_stall", 32'(bus.pipe_stall), 32'(stall));
        pipe_taken = 1'b0;
        md_taken   = 1'b0;
        have       = 1'b0;
        md_commit  = 1'b0;
        c.rd       = '0;
        c.data     = '0;
        if (stall) begin
            c = pend_q.pop_front();
            have = 1'b1;
            md_commit = 1'b1;
            losses = 0;
        end else if (bus.pipe_valid) begin
            c.rd   = bus.pipe_rd;
            c.data = ref_value(bus.pipe_is_load, bus.pipe_funct3, bus.pipe_addr_lo,
                               bus.pipe_alu_result, bus.pipe_mem_rdata);
            have = 1'b1;
            pipe_taken = 1'b1;
            if (pend_q.size() != 0) begin
                losses = (losses < LIMIT) ? losses + 1 : LIMIT;
            end else if (bus.md_valid) begin
                ld.rd   = bus.md_rd;
                ld.data = bus.md_result;
                pend_q.push_back(ld);
                md_taken = 1'b1;
            end
        end else if (pend_q.size() != 0) begin
            c = pend_q.pop_front();
            have = 1'b1;
            md_commit = 1'b1;
            losses = 0;
        end else if (bus.md_valid) begin
            c.rd   = bus.md_rd;
            c.data = bus.md_result;
            have = 1'b1;
            md_commit = 1'b1;
            md_taken = 1'b1;
        end
        if (have && c.rd != 5'd0) exp_q.push_back(c);
        if (md_commit) m_busy[c.rd] = 1'b0;
        if (bus.iss_valid) m_busy[bus.iss_rd] = 1'b1;
        m_busy[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("busy", bus.busy, m_busy);
        check("latency", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic step();
        bit p;
        bit m;
        cycle(p, m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit p_taken;
        bit m_taken;
        idle();
        losses = 0;
        m_busy = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_reg_write", 32'(bus.reg_write), 32'd0);
        check("rst_busy", bus.busy, 32'd0);
        check("rst_md_ready", 32'(bus.md_ready), 32'd1);
        check("rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        reset = 1'b1;

        // ALU commit, then the same to x0.
        set_pipe(5'd5, 1'b0, 3'd0, 2'd0, 32'h0000_1234, 32'd0);
        step();
        check("alu_wr", 32'(bus.write_register), 32'd5);
        check("alu_data", bus.write_data, 32'h0000_1234);
        check("alu_we", 32'(bus.reg_write), 32'd1);
        idle();
        set_pipe(5'd0, 1'b0, 3'd0, 2'd0, 32'h0000_ABCD, 32'd0);
        step();
        check("x0_we", 32'(bus.reg_write), 32'd0);
        check("x0_wr", 32'(bus.write_register), 32'd0);
        check("x0_data", bus.write_data, 32'h0000_ABCD);

        // Load extension on a fixed memory word.
        for (int i = 0; i < 5; i++) begin
            idle();
            set_pipe(5'(i + 1), 1'b1, ld_f3[i], ld_alo[i], 32'hCAFE_F00D, 32'h80FF_7F01);
            step();
            check("load_data", bus.write_data, ld_exp[i]);
        end

        // Collision: pipe first, buffered mul/div on the next idle cycle.
        idle();
        set_pipe(5'd3, 1'b0, 3'd0, 2'd0, 32'h0000_3333, 32'd0);
        set_md(5'd7, 32'h0000_DEAD);
        step();
        check("coll_wr_pipe", 32'(bus.write_register), 32'd3);
        check("coll_md_ready", 32'(bus.md_ready), 32'd0);
        idle();
        step();
        check("coll_wr_md", 32'(bus.write_register), 32'd7);
        check("coll_data_md", bus.write_data, 32'h0000_DEAD);
        check("coll_md_ready_after", 32'(bus.md_ready), 32'd1);

        // Starvation: pipe held busy for six cycles behind a full buffer.
        idle();
        set_pipe(5'd10, 1'b0, 3'd0, 2'd0, 32'h0000_00A0, 32'd0);
        set_md(5'd11, 32'h0000_B0B0);
        step();
        idle();
        p_taken = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (p_taken) set_pipe(5'(12 + k), 1'b0, 3'd0, 2'd0, 32'h100 + 32'(k), 32'd0);
            if (k == 4) begin
                #1;
                check("starve_stall", 32'(bus.pipe_stall), 32'd1);
            end
            cycle(p_taken, m_taken);
            if (k == 4) check("starve_buf_wr", 32'(bus.write_register), 32'd11);
        end
        check("starve_held_wr", 32'(bus.write_register), 32'd16);
        check("starve_held_data", bus.write_data, 32'h0000_0104);

        // Scoreboard set, set-beats-clear, later clear.
        idle();
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        step();
        check("busy9_set", 32'(bus.busy[9]), 32'd1);
        idle();
        set_md(5'd9, 32'h0000_0099);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd9;
        step();
        check("busy9_set_wins", 32'(bus.busy[9]), 32'd1);
        idle();
        set_md(5'd9, 32'h0000_0098);
        step();
        check("busy9_clear", 32'(bus.busy[9]), 32'd0);

        // Asynchronous reset with the buffer full and busy[8] set.
        idle();
        set_pipe(5'd3, 1'b0, 3'd0, 2'd0, 32'h0000_5555, 32'd0);
        set_md(5'd7, 32'h0000_DEAD);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd8;
        step();
        check("pre_rst_busy", bus.busy, 32'h0000_0100);
        idle();
        #2;
        reset = 1'b0;
        #1;
        check("arst_reg_write", 32'(bus.reg_write), 32'd0);
        check("arst_busy", bus.busy, 32'd0);
        check("arst_md_ready", 32'(bus.md_ready), 32'd1);
        check("arst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        check("arst_wr", 32'(bus.write_register), 32'd0);
        check("arst_data", bus.write_data, 32'd0);
        pend_q.delete();
        exp_q.delete();
        losses = 0;
        m_busy = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();

        // Random traffic; pipe and mul/div hold their offer until accepted.
        idle();
        p_taken = 1'b1;
        m_taken = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!bus.pipe_valid || p_taken) begin
                bus.pipe_valid      = ($urandom_range(0, 99) < 70);
                bus.pipe_rd         = 5'($urandom);
                bus.pipe_is_load    = 1'($urandom);
                bus.pipe_funct3     = 3'($urandom);
                bus.pipe_addr_lo    = 2'($urandom);
                bus.pipe_alu_result = $urandom;
                bus.pipe_mem_rdata  = $urandom;
            end
            if (!bus.md_valid || m_taken) begin
                bus.md_valid  = ($urandom_range(0, 99) < 30);
                bus.md_rd     = 5'($urandom);
                bus.md_result = $urandom;
            end
            bus.iss_valid = ($urandom_range(0, 99) < 25);
            bus.iss_rd    = 5'($urandom);
            cycle(p_taken, m_taken);
        end
        idle();
        repeat (3) step();
        check("drain", 32'(exp_q.size() + pend_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
